reg8_piso: RTL and testbench

REG8_PISO -- requirements
Module: reg8_piso

---
 rtl/piso_pkg.sv | 5 +
 rtl/bit_cnt.sv | 19 +
 rtl/reg8_piso.sv | 49 ++++
 tb/tb_reg8_piso.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and default word width for the serializer
package piso_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/bit_cnt.sv
// bit_cnt: loadable down-counter with enable that parks at zero and flags it
module bit_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  // load takes priority; counting stops at zero so it never wraps
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && !zero) cnt <= cnt - 1'b1;
  assign zero = (cnt == '0);
endmodule

// File: rtl/reg8_piso.sv
// reg8_piso: parallel-in serial-out shifter with tick-paced bits and back-to-back reload
module reg8_piso import piso_pkg::*; #(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pl,
  input  logic [WIDTH-1:0] in,
  input  logic             tick,
  output logic             ready,
  output logic             sout,
  output logic             bit_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t           state, state_nx;
  logic [WIDTH-1:0] sr;
  logic             zero, shifting, last, accept;
  // outputs derive from state and the registered word; the final tick opens the reload window
  always_comb begin
    shifting  = (state == SHIFT);
    last      = shifting & zero & tick;
    ready     = !shifting | last;
    accept    = pl & ready;
    state_nx  = accept ? SHIFT : (last ? IDLE : state);
    done      = last;
    bit_valid = shifting;
    sout      = shifting & (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // shift register: capture on accept, advance on tick, clear once the frame ends
  always_ff @(posedge clk or negedge reset)
    if (!reset) sr <= '0;
    else if (accept) sr <= in;
    else if (shifting && tick && !zero) sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    else if (last) sr <= '0;
  bit_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (shifting & tick),
    .load_val (CW'(WIDTH - 1)),
    .zero     (zero)
  );
endmodule

// File: tb/tb_reg8_piso.sv
// tb_reg8_piso: randomized and directed checks of both bit orders against a frame-level model
module tb_reg8_piso;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b0, pl = 1'b0, tick = 1'b0;
  logic [W-1:0] in = '0;
  logic ready_m, sout_m, bv_m, done_m, ready_l, sout_l, bv_l, done_l;
  int checks = 0, errors = 0;
  bit busy = 1'b0;
  logic [W-1:0] word = '0;
  int k = 0;

  always #5 clk = ~clk;

  reg8_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .pl(pl), .in(in), .tick(tick),
    .ready(ready_m), .sout(sout_m), .bit_valid(bv_m), .done(done_m));
  reg8_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .pl(pl), .in(in), .tick(tick),
    .ready(ready_l), .sout(sout_l), .bit_valid(bv_l), .done(done_l));

  function automatic logic [7:0] obs();
    return {sout_m, sout_l, bv_m, bv_l, done_m, done_l, ready_m, ready_l};
  endfunction

  // frame model: busy flag, captured word, index k of the bit on the line
  function automatic logic [7:0] expv();
    logic d, r;
    d = busy && k == W - 1 && tick;
    r = !busy || d;
    return {busy && word[W-1-k], busy && word[k], busy, busy, d, d, r, r};
  endfunction

  task automatic model_edge();
    logic d;
    d = busy && k == W - 1 && tick;
    if (reset) begin
      if ((!busy || d) && pl) begin
        busy = 1'b1; word = in; k = 0;
      end else if (busy && tick) begin
        if (k == W - 1) busy = 1'b0;
        else k++;
      end
    end
  endtask

  task automatic apply(input logic p, input logic [W-1:0] d, input logic t);
    @(negedge clk);
    model_edge();
    pl = p; in = d; tick = t;
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (obs() !== 8'b0000_0011) begin
      errors++; $display("FAIL reset_state: got %b exp %b", obs(), 8'b0000_0011);
    end
    @(negedge clk);
    reset = 1'b1;
    busy = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] got = '0;
    int dn = 0;
    apply(1'b1, 8'haa, 1'b1);
    for (int i = 0; i < W + 2; i++) begin
      if (i > 0) apply(1'b0, W'($urandom), 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL single_frame cyc %0d: got %b exp %b", i, obs(), expv());
      end
      if (i >= 1 && i <= W) got = {got[W-2:0], sout_m};
      if (done_m) dn++;
    end
    checks++;
    if (got !== 8'haa || dn != 1) begin
      errors++; $display("FAIL single_frame_bits: got %h done %0d exp aa done 1", got, dn);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] got = '0;
    int dn = 0;
    apply(1'b1, 8'h55, 1'b1);
    for (int i = 1; i <= 2 * W + 1; i++) begin
      if (i == W) apply(1'b1, 8'h3b, 1'b1);
      else apply(1'b0, W'($urandom), 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %b exp %b", i, obs(), expv());
      end
      if (i <= 2 * W) got = {got[2*W-2:0], sout_m};
      if (done_m) dn++;
    end
    checks++;
    if (got !== 16'h553b || dn != 2) begin
      errors++; $display("FAIL back_to_back_bits: got %h done %0d exp 553b done 2", got, dn);
    end
  endtask

  task automatic test_slow_tick();
    logic [W-1:0] got = '0;
    int dn = 0;
    apply(1'b1, 8'hd4, 1'b0);
    for (int i = 0; i < 3 * W + 3; i++) begin
      apply(1'b0, W'($urandom), 1'(i % 3 == 2));
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL slow_tick cyc %0d: got %b exp %b", i, obs(), expv());
      end
      if (tick && i < 3 * W) got = {got[W-2:0], sout_m};
      if (done_m) dn++;
    end
    checks++;
    if (got !== 8'hd4 || dn != 1) begin
      errors++; $display("FAIL slow_tick_bits: got %h done %0d exp d4 done 1", got, dn);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] got = '0;
    apply(1'b1, 8'haa, 1'b1);
    for (int i = 0; i < 4; i++) apply(1'b0, 8'h00, 1'b1);
    #1 reset = 1'b0;
    #1;
    busy = 1'b0;
    checks++;
    if (obs() !== 8'b0000_0011) begin
      errors++; $display("FAIL abort_async: got %b exp %b", obs(), 8'b0000_0011);
    end
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 8'h55, 1'b1);
    for (int i = 1; i <= W + 1; i++) begin
      apply(1'b0, W'($urandom), 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL abort_restart cyc %0d: got %b exp %b", i, obs(), expv());
      end
      if (i <= W) got = {got[W-2:0], sout_m};
    end
    checks++;
    if (got !== 8'h55) begin
      errors++; $display("FAIL abort_bits: got %h exp 55", got);
    end
  endtask

  task automatic test_ignore_pl();
    logic [W-1:0] got = '1;
    int dn = 0;
    apply(1'b1, 8'h00, 1'b1);
    for (int i = 1; i <= W + 4; i++) begin
      if (i >= 2 && i <= 6) apply(1'b1, 8'hff, 1'b1);
      else apply(1'b0, 8'hff, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL ignore_pl cyc %0d: got %b exp %b", i, obs(), expv());
      end
      if (i <= W) got = {got[W-2:0], sout_m};
      if (done_m) dn++;
    end
    checks++;
    if (got !== 8'h00 || dn != 1) begin
      errors++; $display("FAIL ignore_pl_bits: got %h done %0d exp 00 done 1", got, dn);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] got = '0;
    apply(1'b1, 8'h3b, 1'b1);
    for (int i = 1; i <= W; i++) begin
      apply(1'b0, W'($urandom), 1'b1);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL lsb_first cyc %0d: got %b exp %b", i, obs(), expv());
      end
      got = {got[W-2:0], sout_l};
    end
    checks++;
    if (got !== 8'b1101_1100) begin
      errors++; $display("FAIL lsb_first_bits: got %b exp 11011100", got);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 2) == 0), W'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random cyc %0d: got %b exp %b", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_slow_tick();
    test_abort();
    test_ignore_pl();
    test_lsb_first();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
